oram_path_ctrl: RTL and testbench
=================================

ORAM_PATH_CTRL -- requirements
Module: oram_path_ctrl

Interface
REQ-001 Parameter BYTE_WIDTH, default 8, bits per byte.
REQ-002 Parameter BYTES_PER_BLOCK, default 4, bytes per block; BLK_W = BYTE_WIDTH*BYTES_PER_BLOCK.
REQ-003 Parameter MEMORY_SIZE, default 256, total bytes; NBLK = MEMORY_SIZE/BYTES_PER_BLOCK; TREE_DEPTH = clog2(NBLK).
REQ-004 Parameter K, default 3, tuples per bucket.
REQ-005 Parameter STASH_SIZE, default 8, stash entries (>= K*TREE_DEPTH not required).
REQ-006 Parameter LFSR_SEED, default 16'hACE1, nonzero leaf-generator seed.
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 req_valid  in  1  request present.
REQ-010 req_ready  out  1  controller idle, accepts request.
REQ-011 req_write  in  1  1=write, 0=read.
REQ-012 req_block  in  TREE_DEPTH  block number.
REQ-013 req_wdata  in  BLK_W  write data.
REQ-014 resp_valid  out  1  one-cycle response pulse.
REQ-015 resp_rdata  out  BLK_W  block value before this access (0 if never written).
REQ-016 resp_hit  out  1  block had valid position-map entry at request time.
REQ-017 resp_err  out  1  a tuple was dropped during this access.
REQ-018 overflow  out  1  sticky, set on any dropped tuple, cleared only by reset.

Function
REQ-019 Tree: TREE_DEPTH levels (root level 0, leaves level TREE_DEPTH-1), 2^TREE_DEPTH-1 nodes, 1-based index n; child = 2n+leaf[level], leaf width TREE_DEPTH-1.
REQ-020 Tuple = {valid, block number, leaf, data}; position map = NBLK entries {valid, leaf}.
REQ-021 Leaf source: 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, advances every cycle out of reset; new leaf = lfsr[TREE_DEPTH-2:0].
REQ-022 Handshake: transfer when req_valid && req_ready; req_ready=1 only in IDLE; request fields captured on transfer.
REQ-023 Unmapped block at transfer: assign leaf from LFSR before path read, resp_hit=0.
REQ-024 FSM IDLE -> READ_PATH -> REMAP -> WRITE_PATH -> RESP -> IDLE.
REQ-025 READ_PATH: TREE_DEPTH cycles, one bucket per cycle root to leaf; each valid tuple moved to stash and cleared in tree.
REQ-026 REMAP (1 cycle): locate requested block in stash; resp_rdata = its data (0 if absent); on write replace/insert data; assign fresh LFSR leaf; update position map.
REQ-027 WRITE_PATH: TREE_DEPTH cycles, leaf to root; each level fills up to K stash tuples whose leaf matches the access leaf in bits [level-1:0] (root matches all), lowest stash index first; placed tuples leave stash.
REQ-028 RESP: resp_valid=1 one cycle with resp_rdata, resp_hit, resp_err; then IDLE.
REQ-029 Fixed latency: resp_valid asserted exactly 2*TREE_DEPTH+3 cycles after transfer cycle (15 at defaults).
REQ-030 Stash full on READ_PATH insert or REMAP insert: tuple dropped, resp_err=1, overflow=1; access continues.
REQ-031 Access leaf for READ_PATH and WRITE_PATH is the block's old leaf; remapped block re-enters tree only via prefix match.
REQ-032 Requests with req_valid while busy are ignored (not queued).

Reset
REQ-033 rst_n low (any state, including mid-access): FSM=IDLE, all tree tuples, stash and position map invalid, LFSR=LFSR_SEED, req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_hit=0, resp_err=0, overflow=0; in-flight access discarded without response.

Verification
REQ-034 Write block 5 data 32'hDEADBEEF, then read block 5 -> second response resp_rdata=32'hDEADBEEF, resp_hit=1, resp_err=0.
REQ-035 Read never-written block 12 after reset -> resp_rdata=0, resp_hit=0, resp_valid exactly 15 cycles after transfer.
REQ-036 Write blocks 0..63 with data=block index, read all back in random order -> every value matches, overflow=0 at defaults with K=3, STASH_SIZE=8 (else bench flags and reports).
REQ-037 STASH_SIZE=1, K=1, many writes to distinct blocks -> resp_err=1 on a dropping access, overflow stays 1 until reset.
REQ-038 Assert rst_n low during WRITE_PATH of an access -> no resp_valid, subsequent read of that block returns 0, resp_hit=0.
REQ-039 Hold req_valid=1 continuously -> req_ready low for 2*TREE_DEPTH+3 cycles per access, exactly one resp_valid per accepted request.

Source files
------------

// File: rtl/oram_path_ctrl.sv
// Path ORAM controller: binary bucket tree, stash and position map.
// One access reads a root-to-leaf path into the stash, remaps the block and writes the path back.
module oram_path_ctrl #(
    parameter int          BYTE_WIDTH      = 8,
    parameter int          BYTES_PER_BLOCK = 4,
    parameter int          MEMORY_SIZE     = 256,
    parameter int          K               = 3,
    parameter int          STASH_SIZE      = 8,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    localparam int BLK_W      = BYTE_WIDTH * BYTES_PER_BLOCK,
    localparam int NBLK       = MEMORY_SIZE / BYTES_PER_BLOCK,
    localparam int TREE_DEPTH = $clog2(NBLK)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [TREE_DEPTH-1:0] req_block,
    input  logic [BLK_W-1:0]      req_wdata,
    output logic                  resp_valid,
    output logic [BLK_W-1:0]      resp_rdata,
    output logic                  resp_hit,
    output logic                  resp_err,
    output logic                  overflow
);

    localparam int LW    = TREE_DEPTH - 1;
    localparam int NNODE = (1 << TREE_DEPTH) - 1;
    localparam int LVW   = $clog2(TREE_DEPTH);

    typedef struct packed {
        logic                  v;
        logic [TREE_DEPTH-1:0] blk;
        logic [LW-1:0]         leaf;
        logic [BLK_W-1:0]      data;
    } tuple_t;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_REMAP, S_WRITE, S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [LVW-1:0]        lvl_q, lvl_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic                  wr_q, wr_d;
    logic [TREE_DEPTH-1:0] blk_q, blk_d;
    logic [BLK_W-1:0]      wdata_q, wdata_d;
    logic [BLK_W-1:0]      rdata_q, rdata_d;
    logic [LW-1:0]         leaf_q, leaf_d;
    logic                  hit_q, hit_d;
    logic                  err_q, err_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [BLK_W-1:0]      resp_rdata_q, resp_rdata_d;
    logic                  resp_hit_q, resp_hit_d;
    logic                  resp_err_q, resp_err_d;
    logic                  overflow_q, overflow_d;
    tuple_t                tree_q [NNODE][K];
    tuple_t                tree_d [NNODE][K];
    tuple_t                stash_q [STASH_SIZE];
    tuple_t                stash_d [STASH_SIZE];
    logic                  pm_v_q [NBLK];
    logic                  pm_v_d [NBLK];
    logic [LW-1:0]         pm_leaf_q [NBLK];
    logic [LW-1:0]         pm_leaf_d [NBLK];
    logic                  xfer;
    logic                  drop;
    logic                  placed;
    logic                  found;
    logic [TREE_DEPTH-1:0] node;
    logic [TREE_DEPTH-1:0] nidx;
    logic [LW-1:0]         mask;

    // Node on the access path at lvl_q; mask selects the leaf bits that pick it.
    always_comb begin
        node = TREE_DEPTH'(1);
        mask = '0;
        for (int i = 0; i < LW; i++) begin
            if (i < int'(lvl_q)) begin
                node    = {node[TREE_DEPTH-2:0], leaf_q[i]};
                mask[i] = 1'b1;
            end
        end
        nidx = node - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (xfer) state_d = S_READ;
            S_READ:  if (lvl_q == LVW'(TREE_DEPTH - 1)) state_d = S_REMAP;
            S_REMAP: state_d = S_WRITE;
            S_WRITE: if (lvl_q == '0) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The cycle carrying the response still blocks acceptance.
    always_comb begin
        req_ready = (state_q == S_IDLE) && !resp_valid_q;
        xfer      = req_valid && req_ready;
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_hit   = resp_hit_q;
    assign resp_err   = resp_err_q;
    assign overflow   = overflow_q;

    always_comb begin
        lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        lvl_d        = lvl_q;
        wr_d         = wr_q;
        blk_d        = blk_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        leaf_d       = leaf_q;
        hit_d        = hit_q;
        err_d        = err_q;
        tree_d       = tree_q;
        stash_d      = stash_q;
        pm_v_d       = pm_v_q;
        pm_leaf_d    = pm_leaf_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_hit_d   = 1'b0;
        resp_err_d   = 1'b0;
        drop         = 1'b0;
        placed       = 1'b0;
        found        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    wr_d    = req_write;
                    blk_d   = req_block;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    hit_d   = pm_v_q[req_block];
                    leaf_d  = pm_v_q[req_block] ? pm_leaf_q[req_block] : lfsr_q[LW-1:0];
                    err_d   = 1'b0;
                    lvl_d   = '0;
                end
            end
            S_READ: begin
                for (int k = 0; k < K; k++) begin
                    if (tree_q[nidx][k].v) begin
                        placed = 1'b0;
                        for (int i = 0; i < STASH_SIZE; i++) begin
                            if (!placed && !stash_d[i].v) begin
                                stash_d[i] = tree_q[nidx][k];
                                placed     = 1'b1;
                            end
                        end
                        if (!placed) drop = 1'b1;
                    end
                    tree_d[nidx][k] = '0;
                end
                if (lvl_q != LVW'(TREE_DEPTH - 1)) lvl_d = lvl_q + 1'b1;
            end
            S_REMAP: begin
                for (int i = 0; i < STASH_SIZE; i++) begin
                    if (!found && stash_q[i].v && stash_q[i].blk == blk_q) begin
                        found           = 1'b1;
                        rdata_d         = stash_q[i].data;
                        stash_d[i].leaf = lfsr_q[LW-1:0];
                        if (wr_q) stash_d[i].data = wdata_q;
                    end
                end
                if (!found && wr_q) begin
                    for (int i = 0; i < STASH_SIZE; i++) begin
                        if (!placed && !stash_q[i].v) begin
                            stash_d[i] = {1'b1, blk_q, lfsr_q[LW-1:0], wdata_q};
                            placed     = 1'b1;
                        end
                    end
                    if (!placed) drop = 1'b1;
                end
                pm_v_d[blk_q]    = 1'b1;
                pm_leaf_d[blk_q] = lfsr_q[LW-1:0];
            end
            S_WRITE: begin
                for (int k = 0; k < K; k++) begin
                    placed = 1'b0;
                    for (int i = 0; i < STASH_SIZE; i++) begin
                        if (!placed && stash_d[i].v &&
                            ((stash_d[i].leaf ^ leaf_q) & mask) == '0) begin
                            tree_d[nidx][k] = stash_d[i];
                            stash_d[i]      = '0;
                            placed          = 1'b1;
                        end
                    end
                end
                if (lvl_q != '0) lvl_d = lvl_q - 1'b1;
            end
            S_RESP: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = rdata_q;
                resp_hit_d   = hit_q;
                resp_err_d   = err_q;
            end
            default: ;
        endcase
        if (drop) err_d = 1'b1;
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q        <= '0;
            lfsr_q       <= LFSR_SEED;
            wr_q         <= 1'b0;
            blk_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            leaf_q       <= '0;
            hit_q        <= 1'b0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            overflow_q   <= 1'b0;
            for (int n = 0; n < NNODE; n++)
                for (int k = 0; k < K; k++)
                    tree_q[n][k] <= '0;
            for (int i = 0; i < STASH_SIZE; i++) stash_q[i] <= '0;
            for (int b = 0; b < NBLK; b++) begin
                pm_v_q[b]    <= 1'b0;
                pm_leaf_q[b] <= '0;
            end
        end else begin
            lvl_q        <= lvl_d;
            lfsr_q       <= lfsr_d;
            wr_q         <= wr_d;
            blk_q        <= blk_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            leaf_q       <= leaf_d;
            hit_q        <= hit_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_hit_q   <= resp_hit_d;
            resp_err_q   <= resp_err_d;
            overflow_q   <= overflow_d;
            tree_q       <= tree_d;
            stash_q      <= stash_d;
            pm_v_q       <= pm_v_d;
            pm_leaf_q    <= pm_leaf_d;
        end
    end

endmodule

// File: tb/tb_oram_path_ctrl.sv
// Randomized bench for oram_path_ctrl against a flat block-memory model.
// A second small-stash instance exercises the drop/overflow path.
module tb_oram_path_ctrl;

    localparam int NB  = 64;
    localparam int LAT = 15;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_ready, req_write;
    logic [5:0]  req_block;
    logic [31:0] req_wdata, resp_rdata;
    logic        resp_valid, resp_hit, resp_err, overflow;

    logic        s_rst_n, s_req_valid, s_req_ready, s_req_write;
    logic [5:0]  s_req_block;
    logic [31:0] s_req_wdata, s_resp_rdata;
    logic        s_resp_valid, s_resp_hit, s_resp_err, s_overflow;

    oram_path_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_block(req_block), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_hit(resp_hit), .resp_err(resp_err), .overflow(overflow)
    );

    oram_path_ctrl #(.K(1), .STASH_SIZE(1)) u_small (
        .clk(clk), .rst_n(s_rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_write(s_req_write), .req_block(s_req_block), .req_wdata(s_req_wdata),
        .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata),
        .resp_hit(s_resp_hit), .resp_err(s_resp_err), .overflow(s_overflow)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [NB];
    bit          touched [NB];
    int          ord [NB];
    logic [31:0] rd, d;
    logic        h, e, w;
    logic [5:0]  b;
    int          lat, acc, nresp, low, cyc, tmp, j;
    bit          seen, bad, ovf_seen, ok;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_main();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < NB; i++) begin
            mem[i]     = '0;
            touched[i] = 1'b0;
        end
    endtask

    task automatic access(input logic wi, input logic [5:0] bi, input logic [31:0] di,
                          output logic [31:0] ro, output logic ho, output logic eo,
                          output int lo);
        int n;
        n = 0;
        while (!req_ready && n < 40) begin
            step();
            n++;
        end
        if (n == 40) chk("ready_timeout", req_ready, 1);
        req_valid = 1'b1;
        req_write = wi;
        req_block = bi;
        req_wdata = di;
        lo = 0;
        do begin
            step();
            req_valid = 1'b0;
            lo++;
        end while (!resp_valid && lo < 40);
        if (!resp_valid) chk("resp_timeout", resp_valid, 1);
        ro = resp_rdata;
        ho = resp_hit;
        eo = resp_err;
    endtask

    // Model view: each access returns the last value written (or 0) and hit
    // means the block was accessed since reset.
    task automatic model_acc(input string tag, input logic wi, input logic [5:0] bi,
                             input logic [31:0] di);
        access(wi, bi, di, rd, h, e, lat);
        chk({tag, "_rdata"}, rd, mem[bi]);
        chk({tag, "_hit"}, h, touched[bi]);
        chk({tag, "_err"}, e, 0);
        chk({tag, "_lat"}, lat, LAT);
        if (wi) mem[bi] = di;
        touched[bi] = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; s_rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_block = '0; req_wdata = '0;
        s_req_valid = 1'b0; s_req_write = 1'b0; s_req_block = '0; s_req_wdata = '0;
        step();
        step();
        rst_n = 1'b1;
        s_rst_n = 1'b1;
        step();
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_hit", resp_hit, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_ovf", overflow, 0);

        // Never-written block after reset.
        reset_main();
        model_acc("rd12", 1'b0, 6'd12, 32'h0);

        // Write then read back.
        reset_main();
        model_acc("wr5", 1'b1, 6'd5, 32'hDEADBEEF);
        model_acc("rd5", 1'b0, 6'd5, 32'h0);
        chk("rd5_value", rd, 32'hDEADBEEF);

        // Random mix over 8 blocks: at most 8 live tuples, so nothing can drop.
        reset_main();
        for (int t = 0; t < 60; t++) begin
            b = 6'($urandom_range(7, 0));
            w = 1'($urandom_range(1, 0));
            d = $urandom;
            model_acc("rnd", w, b, d);
        end
        chk("rnd_ovf", overflow, 0);

        // Reset in the middle of the write-back of an access.
        reset_main();
        model_acc("pre", 1'b1, 6'd3, 32'h1234_5678);
        req_valid = 1'b1; req_write = 1'b1; req_block = 6'd3; req_wdata = 32'hCAFE_F00D;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (resp_valid) seen = 1'b1;
            if (i == 2) rst_n = 1'b1;
            step();
        end
        chk("midrst_no_resp", seen, 0);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_rdata", resp_rdata, 0);
        for (int i = 0; i < NB; i++) begin
            mem[i] = '0;
            touched[i] = 1'b0;
        end
        model_acc("midrst_rd", 1'b0, 6'd3, 32'h0);

        // req_valid held high: 15 not-ready cycles and one response per access.
        reset_main();
        acc = 0; nresp = 0; low = 0; cyc = 0;
        req_valid = 1'b1; req_write = 1'b0; req_block = 6'd9;
        while (acc < 3 && cyc < 200) begin
            if (resp_valid) nresp++;
            if (req_ready) begin
                if (acc > 0) chk("hold_rdy_low", low, LAT);
                low = 0;
                acc++;
            end else begin
                low++;
            end
            step();
            cyc++;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (resp_valid) nresp++;
            if (!req_ready) low++;
            step();
        end
        chk("hold_last_low", low, LAT);
        chk("hold_acc", acc, 3);
        chk("hold_resp", nresp, 3);

        // Fill all 64 blocks, read back in shuffled order.
        reset_main();
        ovf_seen = 1'b0;
        for (int i = 0; i < NB; i++) begin
            access(1'b1, 6'(i), 32'(i), rd, h, e, lat);
            chk("bulk_wr_rdata", rd, 0);
            chk("bulk_wr_hit", h, 0);
            if (e) ovf_seen = 1'b1;
            ord[i] = i;
        end
        for (int i = NB - 1; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
        end
        for (int i = 0; i < NB; i++) begin
            access(1'b0, 6'(ord[i]), 32'h0, rd, h, e, lat);
            if (e) ovf_seen = 1'b1;
            ok = (rd == 32'(ord[i])) || (ovf_seen && rd == 32'h0);
            chk("bulk_rd", ok, 1);
            chk("bulk_hit", h, 1);
        end
        if (ovf_seen) $display("NOTE bulk fill: stash overflow at default parameters");
        chk("bulk_ovf_flag", overflow, ovf_seen);

        // Tiny stash and buckets: drops must appear and overflow must stick.
        seen = 1'b0; bad = 1'b0;
        for (int i = 0; i < NB; i++) begin
            cyc = 0;
            while (!s_req_ready && cyc < 40) begin
                step();
                cyc++;
            end
            s_req_valid = 1'b1; s_req_write = 1'b1;
            s_req_block = 6'(i); s_req_wdata = $urandom;
            lat = 0;
            do begin
                step();
                s_req_valid = 1'b0;
                lat++;
            end while (!s_resp_valid && lat < 40);
            if (!s_resp_valid) chk("small_timeout", s_resp_valid, 1);
            if (s_resp_err) seen = 1'b1;
            if (seen && !s_overflow) bad = 1'b1;
        end
        chk("small_err_seen", seen, 1);
        chk("small_ovf_sticky", bad, 0);
        chk("small_ovf", s_overflow, 1);
        s_rst_n = 1'b0;
        step();
        chk("small_ovf_rst", s_overflow, 0);
        s_rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
